// File: rtl/imem_program_loader.sv
// Sequential RV32I encoder/loader: turns instruction descriptors into machine words and
// writes them to instruction memory. Define LOADER_IMM_CHECK_EN to reject out-of-range immediates.
module imem_program_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  finish_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            kind_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [31:0]           imm_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH+1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] BASE_PTR = (ADDR_WIDTH + 2)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_W  = (ADDR_WIDTH + 2)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] WORD_STEP = (ADDR_WIDTH + 2)'(4);

    localparam logic [2:0] KIND_LOAD   = 3'd0;
    localparam logic [2:0] KIND_STORE  = 3'd1;
    localparam logic [2:0] KIND_REG    = 3'd2;
    localparam logic [2:0] KIND_BRANCH = 3'd3;
    localparam logic [2:0] KIND_IMM    = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] enc_r_f(input logic [6:0] f7, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i_f(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [4:0] rd,
                                            input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s_f(input logic [11:0] imm, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // imm holds byte-offset bits [12:1]; bit 0 is implicitly zero
    function automatic logic [31:0] enc_b_f(input logic [12:1] imm, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] enc_j_f(input logic [20:1] imm, input logic [4:0] rd,
                                            input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

    state_t                 state_r;
    logic                   pend_r;
    logic [31:0]            pend_word_r;
    logic                   fin_r;
    logic [ADDR_WIDTH+1:0]  ptr_r;
    logic                   ready_r;
    logic                   we_r;
    logic [ADDR_WIDTH+1:0]  addr_r;
    logic [31:0]            wdata_r;
    logic [ADDR_WIDTH:0]    count_r;
    logic                   busy_r;
    logic                   full_r;
    logic                   done_r;
    logic                   err_r;

    logic [31:0]            word_s;
    logic                   legal_s;
    logic                   imm_ok_s;
    logic                   take_s;
    logic                   write_s;
    logic                   finishing_s;
    logic                   room_s;
    logic [ADDR_WIDTH:0]    cnt_next_s;

    // Encode the presented descriptor and flag illegal kinds
    always_comb begin
        word_s  = 32'h0000_0000;
        legal_s = 1'b1;
        case (kind_i)
            KIND_LOAD:   word_s = enc_i_f(imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD);
            KIND_STORE:  word_s = enc_s_f(imm_i[11:0], rs2_i, rs1_i, funct3_i, OP_STORE);
            KIND_REG:    word_s = enc_r_f(funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_REG);
            KIND_BRANCH: word_s = enc_b_f(imm_i[12:1], rs2_i, rs1_i, funct3_i, OP_BRANCH);
            KIND_IMM:    word_s = enc_i_f(imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM);
            KIND_JAL:    word_s = enc_j_f(imm_i[20:1], rd_i, OP_JAL);
            default: begin
                word_s  = 32'h0000_0000;
                legal_s = 1'b0;
            end
        endcase
    end

`ifdef LOADER_IMM_CHECK_EN
    // Immediate must sign-extend from its format width; branch and jump offsets must be even
    always_comb begin
        case (kind_i)
            KIND_LOAD, KIND_STORE, KIND_IMM:
                imm_ok_s = (&imm_i[31:11]) | ~(|imm_i[31:11]);
            KIND_BRANCH:
                imm_ok_s = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
            KIND_JAL:
                imm_ok_s = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
            default:
                imm_ok_s = 1'b1;
        endcase
    end
`else
    logic unused_imm_s;
    assign imm_ok_s     = 1'b1;
    assign unused_imm_s = ^{imm_i[31:21], imm_i[0]};
`endif

    assign take_s      = valid_i & ready_r;
    assign write_s     = take_s & legal_s & imm_ok_s;
    assign finishing_s = fin_r | finish_i;
    assign cnt_next_s  = count_r + (ADDR_WIDTH + 1)'(pend_r);
    // Room counts both the word landing now and the one being accepted now
    assign room_s      = ({1'b0, cnt_next_s} + (ADDR_WIDTH + 2)'(write_s)) < DEPTH_W;

    // Session FSM, two-stage write pipeline and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            pend_r      <= 1'b0;
            pend_word_r <= 32'h0000_0000;
            fin_r       <= 1'b0;
            ptr_r       <= '0;
            ready_r     <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            count_r     <= '0;
            busy_r      <= 1'b0;
            full_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            we_r   <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r <= ST_LOAD;
                        count_r <= '0;
                        err_r   <= 1'b0;
                        full_r  <= 1'b0;
                        fin_r   <= 1'b0;
                        ptr_r   <= BASE_PTR;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    pend_r      <= write_s;
                    pend_word_r <= word_s;
                    if (take_s && !write_s) begin
                        err_r <= 1'b1;
                    end
                    if (pend_r) begin
                        we_r    <= 1'b1;
                        addr_r  <= ptr_r;
                        wdata_r <= pend_word_r;
                        count_r <= cnt_next_s;
                        ptr_r   <= ptr_r + WORD_STEP;
                    end
                    if (pend_r && count_r == LAST_CNT) begin
                        state_r <= ST_FULL;
                        full_r  <= 1'b1;
                        ready_r <= 1'b0;
                        ptr_r   <= BASE_PTR;
                        fin_r   <= finishing_s;
                    end else if (finishing_s) begin
                        // Let in-flight words land before signalling completion
                        fin_r   <= 1'b1;
                        ready_r <= 1'b0;
                        if (!write_s && !pend_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        ready_r <= room_s;
                    end
                end
                ST_FULL: begin
                    if (fin_r || finish_i) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    pend_r  <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = ready_r;
    assign imem_we_o    = we_r;
    assign imem_addr_o  = addr_r;
    assign imem_wdata_o = wdata_r;
    assign count_o      = count_r;
    assign busy_o       = busy_r;
    assign full_o       = full_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: a default-size instance plus a 4-word instance for fill tests.
module tb_imem_program_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, finish = 1'b0, valid = 1'b0, valid_sm = 1'b0;
    logic [2:0]  kind = 3'd0, f3 = 3'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [6:0]  f7 = 7'd0;
    logic [31:0] imm = 32'd0;

    logic        ready, we, busy, full, done, err;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  count;
    logic        ready_sm, we_sm, busy_sm, full_sm, done_sm, err_sm;
    logic [3:0]  addr_sm;
    logic [31:0] wdata_sm;
    logic [2:0]  count_sm;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [8:0]  cnt;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_sm_q[$];
    logic [9:0] exp_addr, exp_addr_sm;
    logic [8:0] exp_cnt, exp_cnt_sm;
    int checks = 0;
    int errors = 0;
    int streak = 0;
    int max_streak = 0;

    imem_program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish), .valid_i(valid),
        .ready_o(ready), .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm), .imem_we_o(we), .imem_addr_o(addr),
        .imem_wdata_o(wdata), .count_o(count), .busy_o(busy), .full_o(full),
        .done_o(done), .err_o(err)
    );

    imem_program_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_sm (
        .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish), .valid_i(valid_sm),
        .ready_o(ready_sm), .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm), .imem_we_o(we_sm), .imem_addr_o(addr_sm),
        .imem_wdata_o(wdata_sm), .count_o(count_sm), .busy_o(busy_sm), .full_o(full_sm),
        .done_o(done_sm), .err_o(err_sm)
    );

    // Scoreboard for the default instance: every strobe must match the oldest expected write
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected addr=%h data=%h expected no write", addr, wdata);
            end else begin
                e = exp_q.pop_front();
                if ({addr, wdata, count} !== {e.addr, e.data, e.cnt}) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h cnt=%0d expected addr=%h data=%h cnt=%0d",
                             addr, wdata, count, e.addr, e.data, e.cnt);
                end
            end
        end
        streak = we ? streak + 1 : 0;
        if (streak > max_streak) max_streak = streak;
    end

    // Scoreboard for the 4-word instance
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (we_sm) begin
            checks++;
            if (exp_sm_q.size() == 0) begin
                errors++;
                $display("FAIL sm_strobe_unexpected addr=%h data=%h expected no write", addr_sm, wdata_sm);
            end else begin
                e = exp_sm_q.pop_front();
                if ({6'd0, addr_sm, wdata_sm, 6'd0, count_sm} !== {e.addr, e.data, e.cnt}) begin
                    errors++;
                    $display("FAIL sm_write got addr=%h data=%h cnt=%0d expected addr=%h data=%h cnt=%0d",
                             addr_sm, wdata_sm, count_sm, e.addr, e.data, e.cnt);
                end
            end
        end
    end

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 10'd0; exp_cnt = 9'd0; exp_addr_sm = 10'd0; exp_cnt_sm = 9'd0;
        checks++;
        if ({busy, ready, count, err} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL start_state busy/ready/count/err=%b/%b/%0d/%b expected 1/1/0/0", busy, ready, count, err);
        end
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [31:0] im, input logic [31:0] word, input bit expect_wr);
        int n;
        @(negedge clk);
        kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im; valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL send_timeout ready=%b expected 1", ready);
        end else if (expect_wr) begin
            exp_q.push_back('{addr: exp_addr, data: word, cnt: 9'(exp_cnt + 9'd1)});
            exp_addr = exp_addr + 10'd4;
            exp_cnt  = exp_cnt + 9'd1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic finish_session(input bit sm);
        int d;
        logic b;
        int left;
        @(negedge clk);
        valid = 1'b0; valid_sm = 1'b0; finish = 1'b1;
        d = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            finish = 1'b0;
            if (sm ? done_sm : done) d++;
        end
        b = sm ? busy_sm : busy;
        left = sm ? exp_sm_q.size() : exp_q.size();
        checks++;
        if (d != 1) begin errors++; $display("FAIL done_pulse cycles=%0d expected 1", d); end
        checks++;
        if (b !== 1'b0) begin errors++; $display("FAIL busy_after_done busy=%b expected 0", b); end
        checks++;
        if (left != 0) begin errors++; $display("FAIL writes_missing left=%0d expected 0", left); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({we, addr, wdata, count, busy, full, done, err, ready} !== 57'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%h data=%h cnt=%0d busy=%b full=%b done=%b err=%b ready=%b expected all 0",
                     we, addr, wdata, count, busy, full, done, err, ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready ready=%b expected 0", ready); end
    endtask

    task automatic test_single();
        start_session();
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b1);
        idle(2);
        checks++;
        if (count !== 9'd1) begin errors++; $display("FAIL single_count count=%0d expected 1", count); end
        finish_session(1'b0);
    endtask

    task automatic test_back_to_back();
        start_session();
        max_streak = 0;
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b1);
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 32'h00812283, 1'b1);
        send(3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h00512623, 1'b1);
        idle(3);
        checks++;
        if (max_streak != 3) begin errors++; $display("FAIL b2b_streak run=%0d expected 3", max_streak); end
        checks++;
        if (count !== 9'd3) begin errors++; $display("FAIL b2b_count count=%0d expected 3", count); end
        finish_session(1'b0);
    endtask

    task automatic test_branch_jal();
        start_session();
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463, 1'b1);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h010000EF, 1'b1);
        finish_session(1'b0);
        checks++;
        if (count !== 9'd2) begin errors++; $display("FAIL idle_count_hold count=%0d expected 2", count); end
    endtask

    task automatic test_full();
        int acc;
        logic [31:0] w;
        start_session();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (acc < 5) begin
                kind = 3'd4; rd = 5'(acc + 1); rs1 = 5'd0; f3 = 3'd0; imm = 32'(acc * 3);
                valid_sm = 1'b1;
                if (ready_sm) begin
                    w = (imm << 20) | (32'(rd) << 7) | 32'h13;
                    exp_sm_q.push_back('{addr: exp_addr_sm, data: w, cnt: 9'(exp_cnt_sm + 9'd1)});
                    exp_addr_sm = exp_addr_sm + 10'd4;
                    exp_cnt_sm  = exp_cnt_sm + 9'd1;
                    acc++;
                end
            end
        end
        checks++;
        if (acc != 4) begin errors++; $display("FAIL full_accepted got=%0d expected 4", acc); end
        checks++;
        if ({full_sm, ready_sm, count_sm} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL full_state full/ready/count=%b/%b/%0d expected 1/0/4", full_sm, ready_sm, count_sm);
        end
        finish_session(1'b1);
        checks++;
        if (full_sm !== 1'b1) begin errors++; $display("FAIL full_hold full=%b expected 1", full_sm); end
    endtask

    task automatic test_illegal();
        start_session();
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0);
        idle(3);
        checks++;
        if ({err, count} !== {1'b1, 9'd0}) begin
            errors++;
            $display("FAIL illegal_kind err/count=%b/%0d expected 1/0", err, count);
        end
`ifdef LOADER_IMM_CHECK_EN
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h00000013, 1'b0);
        idle(3);
        checks++;
        if (count !== 9'd0) begin errors++; $display("FAIL imm_range_count count=%0d expected 0", count); end
`else
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h00000013, 1'b1);
        idle(3);
        checks++;
        if (count !== 9'd1) begin errors++; $display("FAIL imm_trunc_count count=%0d expected 1", count); end
`endif
        finish_session(1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky err=%b expected 1", err); end
        start_session();
        finish_session(1'b0);
    endtask

    task automatic test_reset_mid();
        start_session();
        send(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700113, 1'b0);
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({we, addr, wdata, count, busy, full, done, err, ready} !== 57'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got we=%b addr=%h data=%h cnt=%0d busy=%b expected all 0",
                     we, addr, wdata, count, busy);
        end
        repeat (2) @(negedge clk);
        start_session();
        send(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700113, 1'b1);
        idle(2);
        finish_session(1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_branch_jal();
        test_full();
        test_illegal();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
